riscv_instr_port_arbiter: RTL

// - Shares one instruction-memory port (req/gnt/rvalid, in-order responses) among NUM_REQ fetch requesters.
// - Requester 0 is the core prefetch buffer; the others are, for example, a debug fetcher or a cache-refill engine.
// - Arbitrates each address phase round-robin and keeps the address stable until grant.
// - Tracks outstanding transactions and routes each rvalid/rdata/err back to the requester that issued it.

---
 rtl/riscv_instr_arb_pkg.sv | 44 ++++
 rtl/riscv_instr_port_arbiter_if.sv | 45 ++++
 rtl/riscv_instr_arb_id_fifo.sv | 73 +++++++
 rtl/riscv_instr_port_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_instr_arb_pkg.sv
// Shared types and helpers for the instruction-port arbiter.
//   ADDR_W      : width of instruction addresses and read data
//   MAX_REQ     : largest supported requester count (bounds rr_pick)
//   arb_state_e : address-phase FSM state (ARB = free to arbitrate,
//                 HOLD = a request is presented to memory and must stay stable)
//   rr_pick     : round-robin selection of the first requester at or after
//                 a pointer, wrapping at n
package riscv_instr_arb_pkg;

  localparam int ADDR_W  = 32;
  localparam int MAX_REQ = 8;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Returns the first index k in ptr, ptr+1, ... (mod n) with req[k] set.
  // Returns 0 when nothing is requesting; callers qualify with |req.
  // ptr is always < n, so a single subtraction performs the wrap.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input logic [3:0]         n);
    logic [2:0] pick;
    logic [3:0] idx;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (4'(i) < n) begin
        idx = {1'b0, ptr} + 4'(i);
        if (idx >= n) begin
          idx = idx - n;
        end
        if (!found && req[idx[2:0]]) begin
          pick  = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/riscv_instr_port_arbiter_if.sv
// Instruction-memory port shared by all fetch requesters.
// Signal names are seen from the arbiter side (_o driven by the arbiter,
// _i driven by memory).
//   instr_req_o     : address-phase request
//   instr_addr_o    : word address, valid while instr_req_o
//   instr_gnt_i     : memory accepts the address phase
//   instr_rvalid_i  : response valid (responses return in request order)
//   instr_rdata_i   : response data, qualified by instr_rvalid_i
//   instr_err_pmp_i : PMP error for the address phase presented this cycle
//
// Handshake: an address phase transfers in a cycle where instr_req_o and
// instr_gnt_i are both high. Once instr_req_o is raised without a grant,
// instr_addr_o holds its value until the grant arrives (unless the owning
// requester withdraws). Every transferred address phase, including one
// flagged by instr_err_pmp_i, is answered by exactly one instr_rvalid_i
// cycle, in order; instr_rvalid_i has no back-pressure.
interface riscv_instr_port_arbiter_if;
  import riscv_instr_arb_pkg::*;

  logic              instr_req_o;
  logic [ADDR_W-1:0] instr_addr_o;
  logic              instr_gnt_i;
  logic              instr_rvalid_i;
  logic [ADDR_W-1:0] instr_rdata_i;
  logic              instr_err_pmp_i;

  modport master (
    output instr_req_o,
    output instr_addr_o,
    input  instr_gnt_i,
    input  instr_rvalid_i,
    input  instr_rdata_i,
    input  instr_err_pmp_i
  );

  modport slave (
    input  instr_req_o,
    input  instr_addr_o,
    output instr_gnt_i,
    output instr_rvalid_i,
    output instr_rdata_i,
    output instr_err_pmp_i
  );

endinterface

// File: rtl/riscv_instr_arb_id_fifo.sv
// In-order FIFO of requester IDs for granted transactions awaiting rvalid.
//   clk, rst : clock, asynchronous active-high reset
//   push     : store push_id (ignored when full)
//   push_id  : requester ID of the transaction just granted
//   pop      : retire the head entry (ignored when empty)
//   head     : ID of the oldest outstanding transaction
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : number of outstanding transactions
// head never reflects a same-cycle push: a push into an empty FIFO becomes
// visible only from the next cycle.
module riscv_instr_arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int ID_W  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [ID_W-1:0]            push_id,
  input  logic                       pop,
  output logic [ID_W-1:0]            head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ID_W-1:0]  entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = entries[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        entries[wr_ptr] <= push_id;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/riscv_instr_port_arbiter.sv
// Shares one instruction-memory port among NUM_REQ fetch requesters.
// Requester 0 is the core prefetch buffer; others may be a debug fetcher or
// a cache-refill engine. Address phases are arbitrated round-robin, the
// address is held stable until grant, and each in-order response is routed
// back to the requester that issued it.
//   clk, rst    : clock, asynchronous active-high reset
//   req_i       : per-requester address-phase request
//   addr_i      : per-requester word address, slice k = requester k
//   gnt_o       : per-requester grant (one-hot or zero)
//   rvalid_o    : per-requester response valid (one-hot or zero)
//   rdata_o     : response data shared by all requesters
//   err_o       : per-requester PMP error, driven together with the grant
//   mem         : instruction-memory port (master side)
//   busy_o      : memory request active or any transaction outstanding
//   proto_err_o : sticky, rvalid seen with nothing outstanding
//   dbg_state   : current address-phase FSM state
// All memory-facing and requester-facing paths are combinational (zero
// latency); while rst is high every output reads 0.
module riscv_instr_port_arbiter
  import riscv_instr_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MAX_OUT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [ADDR_W-1:0]         rdata_o,
  output logic [NUM_REQ-1:0]        err_o,
  riscv_instr_port_arbiter_if.master mem,
  output logic                      busy_o,
  output logic                      proto_err_o,
  output arb_state_e                dbg_state
);

  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  sel_d;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  rr_d;
  logic [SEL_W-1:0]  pick;
  logic [2:0]        pick_raw;
  logic [SEL_W-1:0]  mem_sel;
  logic [SEL_W-1:0]  head_id;
  logic              mem_req;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  out_cnt;
  logic              proto_q;
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];

  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
    return (p == SEL_W'(NUM_REQ - 1)) ? '0 : p + SEL_W'(1);
  endfunction

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_addr
    assign addr_arr[k] = addr_i[k*ADDR_W +: ADDR_W];
  end

  assign pick_raw = rr_pick(MAX_REQ'(req_i), 3'(rr_ptr), 4'(NUM_REQ));
  assign pick     = SEL_W'(pick_raw);

  // ---------------------------------------------------------------------
  // Address-phase FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      sel_q   <= '0;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_ptr  <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_ptr;
    mem_req = 1'b0;
    mem_sel = sel_q;
    push    = 1'b0;
    case (state_q)
      ARB: begin
        // fifo_full is the registered count, so a pop in this same cycle
        // does not let a new request through.
        if (!fifo_full && (|req_i)) begin
          mem_req = 1'b1;
          mem_sel = pick;
          if (mem.instr_gnt_i) begin
            push = 1'b1;
            rr_d = next_ptr(pick);
          end else begin
            sel_d   = pick;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // HOLD is only entered below MAX_OUT and nothing is pushed while
        // in it, so there is always room for the held transaction.
        if (!req_i[sel_q]) begin
          state_d = ARB;
        end else begin
          mem_req = 1'b1;
          if (mem.instr_gnt_i) begin
            push    = 1'b1;
            rr_d    = next_ptr(sel_q);
            state_d = ARB;
          end
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outstanding-transaction tracking
  // ---------------------------------------------------------------------
  assign pop = mem.instr_rvalid_i & ~fifo_empty;

  riscv_instr_arb_id_fifo #(
    .DEPTH (MAX_OUT),
    .ID_W  (SEL_W)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (mem_sel),
    .pop     (pop),
    .head    (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (out_cnt)
  );

  // An rvalid with nothing outstanding cannot be routed; it is dropped and
  // flagged until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_q <= 1'b0;
    end else if (mem.instr_rvalid_i && fifo_empty) begin
      proto_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Output muxing
  // ---------------------------------------------------------------------
  assign mem.instr_req_o  = mem_req & ~rst;
  assign mem.instr_addr_o = (mem_req && !rst) ? addr_arr[mem_sel] : '0;

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    err_o    = '0;
    rdata_o  = '0;
    if (!rst) begin
      gnt_o[mem_sel]    = push;
      rvalid_o[head_id] = pop;
      err_o             = gnt_o & {NUM_REQ{mem.instr_err_pmp_i}};
      rdata_o           = mem.instr_rdata_i;
    end
  end

  assign busy_o      = ~rst & (mem_req | (out_cnt != '0));
  assign proto_err_o = proto_q;
  assign dbg_state   = state_q;

endmodule
